// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte/half/word requests into whole-word memory accesses,
// with sign/zero extension, misalignment faults and read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {StIdle, StRdWait, StWr, StResp} state_e;

  state_e      state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic [2:0]  cnt_q;

  logic        req_fault;
  logic        req_illegal;
  logic        req_misaligned;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign req_ready = (state_q == StIdle);

  // Stores only allow 000/001/010; loads reject 011, 110 and 111.
  always_comb begin
    req_illegal    = req_we ? (req_funct3 > 3'd2)
                            : ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110));
    req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_fault      = req_illegal || req_misaligned;
  end

  always_comb begin
    rd_byte    = mem_read_data[{off_q, 3'b000} +: 8];
    rd_half    = mem_read_data[{off_q[1], 4'b0000} +: 16];
    load_data  = mem_read_data;
    merge_data = mem_read_data;
    unique case (f3_q[1:0])
      2'b00:   load_data = f3_q[2] ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_data = f3_q[2] ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_data = mem_read_data;
    endcase
    if (f3_q[1:0] == 2'b00) begin
      merge_data[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_data[{off_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      we_q           <= 1'b0;
      f3_q           <= '0;
      off_q          <= '0;
      wdata_q        <= '0;
      cnt_q          <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_fault     <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      resp_valid     <= 1'b0;
      mem_we         <= 1'b0;
      mem_write_data <= '0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q     <= req_we;
            f3_q     <= req_funct3;
            off_q    <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            cnt_q    <= '0;
            mem_addr <= {req_addr[31:2], 2'b00};
            if (req_fault) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
              state_q        <= StWr;
              mem_we         <= 1'b1;
              mem_write_data <= req_wdata;
            end else begin
              state_q <= StRdWait;
            end
          end
        end
        StRdWait: begin
          // The word is valid MEM_RD_LAT cycles after the registered address settles.
          if (cnt_q == 3'(MEM_RD_LAT)) begin
            if (we_q) begin
              state_q        <= StWr;
              mem_we         <= 1'b1;
              mem_write_data <= merge_data;
            end else begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_fault <= 1'b0;
              resp_rdata <= load_data;
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        StWr: begin
          state_q    <= StResp;
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          resp_rdata <= '0;
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (read latency 1 and 3) on a word memory model,
// checked against a byte-addressed reference memory.
module tb_load_store_unit;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic        clk;
  logic        rst;
  logic        mem_clear;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_fault [2];
  logic        mem_we [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_write_data [2];
  logic [31:0] mem_read_data [2];

  logic [31:0] mem [2][256];
  logic [31:0] pipe [2][4];
  logic [7:0]  ref_b [2][1024];
  int          we_pulses [2] = '{0, 0};
  int          tests = 0;
  int          fails = 0;

  load_store_unit #(.MEM_RD_LAT(LAT0)) u_lsu0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_fault(resp_fault[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_write_data(mem_write_data[0]), .mem_read_data(mem_read_data[0])
  );

  load_store_unit #(.MEM_RD_LAT(LAT1)) u_lsu1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_fault(resp_fault[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_write_data(mem_write_data[1]), .mem_read_data(mem_read_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic int lat_of(int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [31:0] ref_word(int k, int idx);
    return {ref_b[k][4*idx+3], ref_b[k][4*idx+2], ref_b[k][4*idx+1], ref_b[k][4*idx]};
  endfunction

  // Memory model: synchronous write, read data valid MEM_RD_LAT cycles after the address.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_clear) begin
        for (int i = 0; i < 256; i++) mem[k][i] <= init_word(i);
      end else if (mem_we[k]) begin
        mem[k][mem_addr[k][9:2]] <= mem_write_data[k];
      end
      pipe[k][0] <= mem[k][mem_addr[k][9:2]];
      for (int s = 1; s < 4; s++) pipe[k][s] <= pipe[k][s-1];
      if (mem_we[k]) we_pulses[k] <= we_pulses[k] + 1;
    end
  end
  assign mem_read_data[0] = pipe[0][LAT0-1];
  assign mem_read_data[1] = pipe[1][LAT1-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference: legality, alignment, byte-level memory, and latency in cycles from accept.
  task automatic predict(input int k, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit commit, output logic [31:0] rd,
                         output bit flt, output int lat, output int pulses);
    int nb;
    int a;
    bit legal;
    longint unsigned v;
    nb     = 1 << f3[1:0];
    a      = int'(addr[9:0]);
    legal  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    flt    = !legal || ((a % nb) != 0);
    rd     = '0;
    pulses = 0;
    if (flt) begin
      lat = 1;
    end else if (we) begin
      if (commit) for (int b = 0; b < nb; b++) ref_b[k][a+b] = 8'(wdata >> (8*b));
      pulses = 1;
      lat    = (nb == 4) ? 2 : lat_of(k) + 3;
    end else begin
      v = 0;
      for (int b = 0; b < nb; b++) v |= longint'(ref_b[k][a+b]) << (8*b);
      if (!f3[2] && nb < 4 && v[8*nb-1]) v |= 64'hFFFF_FFFF_FFFF_FFFF << (8*nb);
      rd  = v[31:0];
      lat = lat_of(k) + 2;
    end
  endtask

  task automatic drive(input int k, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid[k]  = 1'b1;
    req_we[k]     = we;
    req_funct3[k] = f3;
    req_addr[k]   = addr;
    req_wdata[k]  = wdata;
  endtask

  task automatic txn(input int k, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input string tag, output logic [31:0] got);
    logic [31:0] rd;
    bit flt;
    int lat, pl, n, p0;
    predict(k, we, f3, addr, wdata, 1'b1, rd, flt, lat, pl);
    @(negedge clk);
    chk({tag, " ready_idle"}, 32'(req_ready[k]), 32'd1);
    drive(k, we, f3, addr, wdata);
    p0 = we_pulses[k];
    @(posedge clk); #1;
    n = 1;
    // Scramble the request after accept; the latched copy must be used.
    drive(k, ~we, ~f3, ~addr, ~wdata);
    req_valid[k] = 1'b0;
    while (!resp_valid[k] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    got = resp_rdata[k];
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " rdata"}, resp_rdata[k], rd);
    chk({tag, " fault"}, 32'(resp_fault[k]), 32'(flt));
    chk({tag, " ready_resp"}, 32'(req_ready[k]), 32'd0);
    @(posedge clk); #1;
    chk({tag, " pulse_end"}, 32'(resp_valid[k]), 32'd0);
    chk({tag, " rdata_hold"}, resp_rdata[k], rd);
    chk({tag, " we_pulses"}, 32'(we_pulses[k] - p0), 32'(pl));
    if (we && !flt) chk({tag, " mem_word"}, mem[k][addr[9:2]], ref_word(k, int'(addr[9:2])));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got, rd1, rd2;
    bit f1, f2;
    int l1, l2, pl1, pl2, n, m, p0;
    logic [31:0] w_before;

    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_funct3[k] = '0;
      req_addr[k]  = '0;   req_wdata[k] = '0;
      for (int i = 0; i < 256; i++)
        for (int b = 0; b < 4; b++) ref_b[k][4*i+b] = 8'(init_word(i) >> (8*b));
    end
    rst = 1'b0;
    mem_clear = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset resp_valid", 32'(resp_valid[k]), 32'd0);
      chk("reset resp_rdata", resp_rdata[k], 32'd0);
      chk("reset resp_fault", 32'(resp_fault[k]), 32'd0);
      chk("reset mem_we", 32'(mem_we[k]), 32'd0);
      chk("reset mem_addr", mem_addr[k], 32'd0);
      chk("reset mem_write_data", mem_write_data[k], 32'd0);
      chk("reset req_ready", 32'(req_ready[k]), 32'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    mem_clear = 1'b0;

    for (int k = 0; k < 2; k++) begin
      txn(k, 1'b1, 3'b010, 32'h0010_0004, 32'hDEAD_BEEF, "sw_init1", got);
      txn(k, 1'b0, 3'b010, 32'h0010_0004, 32'h0, "lw", got);
      chk("lw value", got, 32'hDEAD_BEEF);
      txn(k, 1'b1, 3'b010, 32'h0010_0004, 32'h8011_2233, "sw_init2", got);
      txn(k, 1'b0, 3'b000, 32'h0010_0007, 32'h0, "lb", got);
      chk("lb value", got, 32'hFFFF_FF80);
      txn(k, 1'b0, 3'b100, 32'h0010_0007, 32'h0, "lbu", got);
      chk("lbu value", got, 32'h0000_0080);
      txn(k, 1'b1, 3'b010, 32'h0010_0000, 32'h1122_3344, "sw_init3", got);
      txn(k, 1'b1, 3'b000, 32'h0010_0001, 32'h0000_00AB, "sb", got);
      txn(k, 1'b0, 3'b010, 32'h0010_0000, 32'h0, "lw_after_sb", got);
      chk("sb merge value", got, 32'h1122_AB44);
      txn(k, 1'b0, 3'b001, 32'h0010_0003, 32'h0, "lh_misaligned", got);
      txn(k, 1'b1, 3'b010, 32'h0010_0002, 32'h5555_5555, "sw_misaligned", got);
      txn(k, 1'b0, 3'b011, 32'h0010_0000, 32'h0, "ld_illegal", got);
      txn(k, 1'b1, 3'b100, 32'h0010_0000, 32'h1234_5678, "st_f3_100", got);
      txn(k, 1'b0, 3'b101, 32'h0010_0006, 32'h0, "lhu", got);
    end

    // Back-to-back: req_valid stays high across SH then LHU to the half just written.
    for (int k = 0; k < 2; k++) begin
      predict(k, 1'b1, 3'b001, 32'h0010_0012, 32'h0000_C3A5, 1'b1, rd1, f1, l1, pl1);
      predict(k, 1'b0, 3'b101, 32'h0010_0012, 32'h0, 1'b1, rd2, f2, l2, pl2);
      @(negedge clk);
      drive(k, 1'b1, 3'b001, 32'h0010_0012, 32'h0000_C3A5);
      p0 = we_pulses[k];
      @(posedge clk); #1;
      n = 1;
      drive(k, 1'b0, 3'b101, 32'h0010_0012, 32'h0);
      while (!resp_valid[k] && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      chk("b2b sh latency", 32'(n), 32'(l1));
      chk("b2b ready_in_resp", 32'(req_ready[k]), 32'd0);
      @(posedge clk); #1;
      chk("b2b ready_after_resp", 32'(req_ready[k]), 32'd1);
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      m = 1;
      while (!resp_valid[k] && m < 40) begin
        @(posedge clk); #1;
        m++;
      end
      chk("b2b lhu latency", 32'(m), 32'(l2));
      chk("b2b lhu rdata", resp_rdata[k], rd2);
      chk("b2b lhu value", resp_rdata[k], 32'h0000_C3A5);
      chk("b2b we_pulses", 32'(we_pulses[k] - p0), 32'd1);
      @(posedge clk); #1;
    end

    // Reset while an SB sits in RD_WAIT: nothing may be written.
    for (int k = 0; k < 2; k++) begin
      w_before = ref_word(k, 8);
      @(negedge clk);
      drive(k, 1'b1, 3'b000, 32'h0010_0022, 32'h0000_0077);
      p0 = we_pulses[k];
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rst mem_we", 32'(mem_we[k]), 32'd0);
      chk("rst req_ready", 32'(req_ready[k]), 32'd1);
      chk("rst resp_valid", 32'(resp_valid[k]), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst no_write", 32'(we_pulses[k] - p0), 32'd0);
      chk("rst mem_unchanged", mem[k][8], w_before);
      chk("rst ready_after", 32'(req_ready[k]), 32'd1);
      txn(k, 1'b0, 3'b010, 32'h0010_0020, 32'h0, "lw_after_rst", got);
    end

    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 30; t++) begin
        bit r_we;
        logic [2:0] r_f3;
        logic [31:0] r_addr;
        r_we   = 1'($urandom_range(0, 1));
        r_f3   = 3'($urandom_range(0, 7));
        r_addr = 32'h0010_0000 | 32'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~(32'(1 << r_f3[1:0]) - 32'd1);
        txn(k, r_we, r_f3, r_addr, $urandom, "random", got);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
